fetch_pc_unit: RTL

Parametrised program-counter and fetch-control unit for the MiniCPU family, the successor to the simple up/down `PC` counter. It produces the instruction-memory address each cycle and supports sequential increment, stall, absolute jump, call and return. Calls and returns use an internal return-address stack of configurable depth. It sits between the ALU/branch logic, which supplies redirect commands, and `InsMemory`, which consumes `pc`.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_pc_unit_if.sv | 36 +++
 rtl/fetch_pc_unit_ret_stack.sv | 59 +++++
 rtl/fetch_pc_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MiniCPU fetch path.
//   pc_action_e    : the single action the PC register performs in a cycle
//   ADDR_W_DEFAULT : default width of the PC and of all instruction addresses
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_INC,
        ACT_JMP,
        ACT_CALL,
        ACT_RET
    } pc_action_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-control bus between the redirect source (ALU/branch logic) and the
// PC unit.
//   master : drives stall/jmp/call/ret/target/clr_err, observes PC and status
//   slave  : the PC unit; consumes the requests, drives pc, depth and flags
interface fetch_pc_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               stall;
    logic               jmp;
    logic               call;
    logic               ret;
    logic [ADDR_W-1:0]  target;
    logic               clr_err;
    logic [ADDR_W-1:0]  pc;
    logic [DEPTH_W-1:0] depth;
    logic               stack_full;
    logic               stack_empty;
    logic               err_overflow;
    logic               err_underflow;

    modport master (
        output stall, jmp, call, ret, target, clr_err,
        input  pc, depth, stack_full, stack_empty, err_overflow, err_underflow
    );

    modport slave (
        input  stall, jmp, call, ret, target, clr_err,
        output pc, depth, stack_full, stack_empty, err_overflow, err_underflow
    );

endinterface

// File: rtl/fetch_pc_unit_ret_stack.sv
// ret_stack: return-address LIFO of STACK_DEPTH entries of ADDR_W bits.
//   clk, reset : clock, asynchronous active-high reset (clears depth only)
//   push, data : write data on top; ignored while full
//   pop        : discard the top entry; ignored while empty
//   top        : current top entry (meaningless while empty)
//   depth      : occupancy, 0..STACK_DEPTH
//   full/empty : decoded combinationally from depth
module ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1),
    localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [ADDR_W-1:0]  data,
    output logic [ADDR_W-1:0]  top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (depth == DEPTH_W'(STACK_DEPTH));
    assign empty   = (depth == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Entry 0 is returned while empty; the caller never uses it then.
    assign top = empty ? mem[0] : mem[IDX_W'(depth - DEPTH_W'(1))];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth <= '0;
        end else if (do_push) begin
            depth <= depth + DEPTH_W'(1);
        end else if (do_pop) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // NOTE: the storage array has no reset; only depth is reset, and entries
    // at or above depth are never read, so stale contents are harmless and
    // the array can map onto plain flops or a register file.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[IDX_W'(depth)] <= data;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and fetch control for MiniCPU.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : fetch_pc_unit_if slave modport
//                in : stall, jmp, call, ret, target, clr_err
//                out: pc, depth, stack_full, stack_empty,
//                     err_overflow, err_underflow (sticky)
// One action per cycle, priority stall > ret > call > jmp > increment.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W      = ADDR_W_DEFAULT,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.slave  bus
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    pc_action_e         action;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  stack_top;
    logic [DEPTH_W-1:0] stack_depth;
    logic               stack_full;
    logic               stack_empty;
    logic               ovf_q;
    logic               unf_q;
    logic               ovf_set;
    logic               unf_set;

    // Wraps modulo 2^ADDR_W with no flag.
    assign pc_inc = pc_q + ADDR_W'(1);

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        action = ACT_INC;
        if (bus.stall) begin
            action = ACT_HOLD;
        end else if (bus.ret) begin
            action = ACT_RET;
        end else if (bus.call) begin
            action = ACT_CALL;
        end else if (bus.jmp) begin
            action = ACT_JMP;
        end
    end

    always_comb begin
        pc_next = pc_inc;
        unique case (action)
            ACT_HOLD: pc_next = pc_q;
            ACT_INC:  pc_next = pc_inc;
            ACT_JMP:  pc_next = bus.target;
            ACT_CALL: pc_next = bus.target;
            // An empty-stack return degrades to a plain increment.
            ACT_RET:  pc_next = stack_empty ? pc_inc : stack_top;
            default:  pc_next = pc_inc;
        endcase
    end

    assign ovf_set = (action == ACT_CALL) && stack_full;
    assign unf_set = (action == ACT_RET)  && stack_empty;

    // The stack itself drops a push when full and a pop when empty.
    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (action == ACT_CALL),
        .pop   (action == ACT_RET),
        .data  (pc_inc),
        .top   (stack_top),
        .depth (stack_depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Set-dominant sticky flags; clr_err acts even while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set || (ovf_q && !bus.clr_err);
            unf_q <= unf_set || (unf_q && !bus.clr_err);
        end
    end

    assign bus.pc            = pc_q;
    assign bus.depth         = stack_depth;
    assign bus.stack_full    = stack_full;
    assign bus.stack_empty   = stack_empty;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;

endmodule
